// File: rtl/synth_top.sv
// Tone synthesiser top: clock divider for I2S clocks, phase-accumulator tone, I2S serializer.
// Define SYNTH_SAW_EN to replace the square wave with a full-scale sawtooth.
module synth_top #(
  parameter logic [23:0] TONE_INC = 24'd151183,
  parameter logic [23:0] AMP      = 24'h100000
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] led,
  output logic       mclk,
  output logic       lrck,
  output logic       sck,
  output logic       sdout
);

  logic [10:0] cnt;
  logic [23:0] phase;
  logic [23:0] sample_reg;
  logic [23:0] next_sample;
  logic        frame_end;
  logic        slot_end;
  logic [4:0]  next_slot;
  logic [4:0]  bit_idx;

  // All I2S clocks are plain taps of the free-running frame counter
  assign mclk = cnt[1];
  assign sck  = cnt[4];
  assign lrck = cnt[10];

  always_comb begin
    frame_end = (cnt == 11'd2047);
    slot_end  = (cnt[4:0] == 5'd31);
    next_slot = cnt[9:5] + 5'd1;
    bit_idx   = 5'd24 - next_slot;
  end

  always_comb begin
    next_sample = '0;
`ifdef SYNTH_SAW_EN
    next_sample = {~phase[23], phase[22:0]};
`else
    next_sample = phase[23] ? (~AMP + 24'd1) : AMP;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 11'd1;
    end
  end

  // New sample is taken from the old phase once per frame, at the counter wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      phase      <= '0;
      sample_reg <= '0;
      led        <= '0;
    end else if (frame_end) begin
      sample_reg <= next_sample;
      phase      <= phase + TONE_INC;
      led        <= next_sample[23:16];
    end
  end

  // Data changes at the end of each SCK period, so the MSB lags LRCK by one slot
  always_ff @(posedge clk) begin
    if (rst) begin
      sdout <= 1'b0;
    end else if (slot_end) begin
      if ((next_slot >= 5'd1) && (next_slot <= 5'd24)) begin
        sdout <= sample_reg[bit_idx];
      end else begin
        sdout <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_synth_top.sv
// Self-checking bench for synth_top: random reset pulses and run lengths against an arithmetic model.
// Honours SYNTH_SAW_EN so the same bench checks either tone build.
module tb_synth_top;

  // Increment scaled by 16 so the phase sign flip is reached within a few frames
  localparam logic [23:0] TB_INC = 24'd2418928;
  localparam logic [23:0] TB_AMP = 24'h100000;

  logic       clk;
  logic       rst;
  logic [7:0] led;
  logic       mclk;
  logic       lrck;
  logic       sck;
  logic       sdout;

  int total;
  int bad;
  int n;
  int bitpos;
  logic [23:0] cap;
  logic prevLrck;
  logic prevSck;

  synth_top #(
    .TONE_INC(TB_INC),
    .AMP     (TB_AMP)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .led  (led),
    .mclk (mclk),
    .lrck (lrck),
    .sck  (sck),
    .sdout(sdout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word transmitted during frame k after reset: frame 0 is silent, frame k uses phase (k-1)*inc
  function automatic logic [23:0] toneWord(input int k);
    longint ph;
    longint w;
    if (k == 0) return 24'd0;
    ph = (longint'(k - 1) * longint'(TB_INC)) % 64'd16777216;
`ifdef SYNTH_SAW_EN
    w = (ph + 64'd8388608) % 64'd16777216;
`else
    w = (ph < 64'd8388608) ? longint'(TB_AMP) : (64'd16777216 - longint'(TB_AMP));
`endif
    return 24'(w);
  endfunction

  task automatic checkOutput(input string tag, input logic [23:0] got, input logic [23:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (n=%0d)", tag, got, exp, n);
    end
  endtask

  // Drives rst for a number of cycles and checks every output after each edge
  task automatic applyStimulus(input logic r, input int cycles);
    int c;
    int k;
    int s;
    logic [23:0] w;
    logic expSd;
    for (int i = 0; i < cycles; i++) begin
      rst = r;
      @(posedge clk);
      #1;
      if (r) n = 0;
      else n = n + 1;
      c = n % 2048;
      k = n / 2048;
      w = toneWord(k);
      s = (c / 32) % 32;
      expSd = ((s >= 1) && (s <= 24)) ? w[24 - s] : 1'b0;
      checkOutput("mclk", {23'd0, mclk}, 24'((c / 2) % 2));
      checkOutput("sck", {23'd0, sck}, 24'((c / 16) % 2));
      checkOutput("lrck", {23'd0, lrck}, 24'((c / 1024) % 2));
      checkOutput("sdout", {23'd0, sdout}, {23'd0, expSd});
      checkOutput("led", {16'd0, led}, {16'd0, w[23:16]});
      if (r) begin
        bitpos = 0;
        cap = '0;
      end else begin
        if (lrck !== prevLrck) begin
          bitpos = 0;
          cap = '0;
        end
        if (sck && !prevSck) begin
          bitpos++;
          if ((bitpos >= 2) && (bitpos <= 25)) cap = {cap[22:0], sdout};
          if (bitpos == 25) checkOutput(lrck ? "word_r" : "word_l", cap, w);
        end
      end
      prevLrck = lrck;
      prevSck = sck;
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    n = 0;
    bitpos = 0;
    cap = '0;
    prevLrck = 1'b0;
    prevSck = 1'b0;
    rst = 1'b1;
    applyStimulus(1'b1, 5);
    applyStimulus(1'b0, 14000);
    for (int seg = 0; seg < 5; seg++) begin
      applyStimulus(1'b1, int'($urandom_range(1, 6)));
      applyStimulus(1'b0, int'($urandom_range(100, 5000)));
    end
    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, 2100);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
